lcd_timing_gen: RTL
===================

# lcd_timing_gen

Generates the pixel-clock-domain raster timing (`de`, `hsync`, `vsync`) that drives both the LCD panel and the `pclk` side of the video buffer, which scales and colour-maps Game Boy frames. Horizontal and vertical counters walk a parameterised raster. Outputs are registered, with a programmable extra delay to match downstream memory/LUT latency. A frame-granular enable starts and stops scan-out cleanly on frame boundaries.

## Interface
- `H_ACTIVE`, 800, active pixels per line
- `H_FP`, 40, horizontal front porch (clocks)
- `H_SYNC`, 48, hsync pulse width (clocks)
- `H_BP`, 88, horizontal back porch (clocks)
- `V_ACTIVE`, 480, active lines per frame
- `V_FP`, 13, vertical front porch (lines)
- `V_SYNC`, 3, vsync pulse width (lines)
- `V_BP`, 32, vertical back porch (lines)
- `PIPE_DELAY`, 0, extra output register stages, 0..4

Ports:
- `pclk` in 1: pixel clock; the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: scan-out enable, acted on only at frame boundaries.
- `de` out 1: data enable, high during active pixels.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `frame_start` out 1: one-clock pulse on the first pixel of each frame (h=0, v=0).
- `pixel_x` out 11: horizontal count, aligned with `de`.
- `pixel_y` out 11: vertical count, aligned with `de`.
- `running` out 1: high while in the RUN state (undelayed).

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be ≤ 2048; checked by elaboration assertion.
- Internal counters `h` (0..H_TOTAL-1) and `v` (0..V_TOTAL-1).
  - `h` increments every clock in RUN.
  - At `h` = H_TOTAL-1, `h` wraps to 0 and `v` increments.
  - At `v` = V_TOTAL-1 with `h` wrapping, `v` wraps to 0.
- Region order within a line and within a frame: active, front porch, sync, back porch.
- Raw signals, combinational from `h`/`v`:
  - de_raw = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hs_raw = !(H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC)
  - vs_raw = !(V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC)
  - vsync edges therefore coincide with h=0 of the line.
  - fs_raw = (h==0 && v==0 && RUN)
- State machine:
  - IDLE: `h`=`v`=0; raw outputs forced idle (de 0, hsync 1, vsync 1, fs 0). If `en`=1, go to RUN; the first RUN cycle has h=0, v=0.
  - RUN: counters advance. On the last clock of the frame (h=H_TOTAL-1, v=V_TOTAL-1), `en` is sampled. If `en`=0, go to IDLE; otherwise wrap and continue.
  - Deasserting `en` mid-frame never truncates a frame.
  - Toggling `en` within a frame has no effect other than its value at the last clock.
- Reset (any time, including mid-frame) enters IDLE immediately. After release, scan-out restarts from h=0, v=0 on the first clock with `en`=1.
- All outputs except `running` pass through one output register plus PIPE_DELAY further stages, all delayed identically.

## Timing
- Reset values: `de`=0, `hsync`=1, `vsync`=1, `frame_start`=0, `pixel_x`=0, `pixel_y`=0, `running`=0. All pipeline stages are cleared to these values.
- Latency from counter state to outputs is 1+PIPE_DELAY clocks. `running` follows the state register with no extra delay.
- IDLE→RUN: `frame_start` rises 1+PIPE_DELAY clocks after `running` rises.
- Period between `frame_start` pulses in continuous RUN: exactly H_TOTAL×V_TOTAL clocks.
- `de` high run length per active line: exactly H_ACTIVE clocks. There are V_ACTIVE such runs per frame.

## Test plan
- **Reset and start, default parameters.** Hold `rst`=0 for 5 clocks, release, set `en`=1. Required: outputs at reset values until started; `frame_start` pulses 1 clock after `running`; `pixel_x`,`pixel_y`=0,0 with `de`=1 on that clock.
- **Line timing, default parameters.** Per line: `de` high 800 clocks; `hsync` low for 48 clocks starting at h=840; line period 976 clocks.
- **Frame timing, default parameters.** `vsync` low for lines 493..495 (3×976 clocks), with edges aligned to the hsync line start. Successive `frame_start` pulses are 515328 clocks apart.
- **Enable handling.** Drop `en` at h=100, v=200; the frame completes, then `running`=0 with outputs idle. Pulse `en` for 1 clock mid-frame while running; there is no effect.
- **Reset mid-frame.** Assert `rst` at h=500, v=300. Outputs return to reset values asynchronously in the same clock; after release with `en`=1, `frame_start` fires.
- **PIPE_DELAY=3.** Every output edge is shifted exactly 3 clocks relative to the PIPE_DELAY=0 run with identical stimulus; `running` is unchanged.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the LCD panel and the pclk side of the video buffer.
// A frame-granular IDLE/RUN machine walks h/v counters; outputs pass through a matched delay pipeline.
module lcd_timing_gen #(
   parameter int H_ACTIVE   = 800,
   parameter int H_FP       = 40,
   parameter int H_SYNC     = 48,
   parameter int H_BP       = 88,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 13,
   parameter int V_SYNC     = 3,
   parameter int V_BP       = 32,
   parameter int PIPE_DELAY = 0
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        en,
   output logic        de,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start,
   output logic [10:0] pixel_x,
   output logic [10:0] pixel_y,
   output logic        running
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
      $error("lcd_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
   end
   if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
      $error("lcd_timing_gen: PIPE_DELAY must be within 0..4");
   end

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT_W  = 12'(V_ACTIVE);
   localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {IDLE, RUN} state_t;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [10:0] x;
      logic [10:0] y;
   } raster_t;

   localparam raster_t IDLE_OUT = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, x: 11'd0, y: 11'd0};

   state_t      state;
   logic [10:0] h;
   logic [10:0] v;
   raster_t     raw;
   raster_t     pipe [0:PIPE_DELAY];
   logic [11:0] h_ext;
   logic [11:0] v_ext;

   // en only matters in IDLE or on the very last clock of a frame, so frames are never cut short
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         h     <= 11'd0;
         v     <= 11'd0;
      end else begin
         case (state)
            IDLE: begin
               h <= 11'd0;
               v <= 11'd0;
               if (en) state <= RUN;
            end
            RUN: begin
               if (h == H_LAST) begin
                  h <= 11'd0;
                  if (v == V_LAST) begin
                     v <= 11'd0;
                     if (!en) state <= IDLE;
                  end else begin
                     v <= v + 11'd1;
                  end
               end else begin
                  h <= h + 11'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign h_ext = {1'b0, h};
   assign v_ext = {1'b0, v};

   always_comb begin
      raw = IDLE_OUT;
      if (state == RUN) begin
         raw.de = (h_ext < H_ACT_W) && (v_ext < V_ACT_W);
         raw.hs = !((h_ext >= HS_START) && (h_ext < HS_END));
         raw.vs = !((v_ext >= VS_START) && (v_ext < VS_END));
         raw.fs = (h == 11'd0) && (v == 11'd0);
         raw.x  = h;
         raw.y  = v;
      end
   end

   // Stage 0 is the mandatory output register; the rest absorb downstream memory/LUT latency
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i <= PIPE_DELAY; i++) pipe[i] <= IDLE_OUT;
      end else begin
         pipe[0] <= raw;
         for (int i = 1; i <= PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign de          = pipe[PIPE_DELAY].de;
   assign hsync       = pipe[PIPE_DELAY].hs;
   assign vsync       = pipe[PIPE_DELAY].vs;
   assign frame_start = pipe[PIPE_DELAY].fs;
   assign pixel_x     = pipe[PIPE_DELAY].x;
   assign pixel_y     = pipe[PIPE_DELAY].y;
   assign running     = (state == RUN);

endmodule
